// File: rtl/tank_render_pkg.sv
// rtl/tank_render_pkg.sv - shared types, screen defaults and texel rotation for the tank renderer
package tank_render_pkg;

    localparam int SCREEN_W_DEFAULT = 640;
    localparam int SCREEN_H_DEFAULT = 480;
    localparam int TEX_W            = 8;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BLINK = 1'b1
    } blink_state_t;

    typedef struct packed {
        logic [TEX_W-1:0] su;
        logic [TEX_W-1:0] sv;
    } texel_t;

    // Maps an on-screen texel (u,v) back to the upright source texel; m is SPRITE_N-1.
    function automatic texel_t rotate_texel(input logic [TEX_W-1:0] u,
                                            input logic [TEX_W-1:0] v,
                                            input dir_t             d,
                                            input logic [TEX_W-1:0] m);
        texel_t t;
        case (d)
            DIR_RIGHT: begin t.su = v;     t.sv = m - u; end
            DIR_DOWN:  begin t.su = m - u; t.sv = m - v; end
            DIR_LEFT:  begin t.su = m - v; t.sv = u;     end
            default:   begin t.su = u;     t.sv = v;     end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/sprite_delay_line.sv
// rtl/sprite_delay_line.sv - resettable DEPTH-stage shift register for pipeline side-band bits
module sprite_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 1
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/tank_sprite_renderer.sv
// rtl/tank_sprite_renderer.sv - positioned, scaled, rotated tank sprite with hit blink
// Optional macro TANK_ANIM_EN adds a tread-animation frame select as the ROM address MSB.
module tank_sprite_renderer
    import tank_render_pkg::*;
#(
    parameter int SPRITE_N     = 32,
    parameter int SCALE_SHIFT  = 0,
    parameter int IDX_W        = 4,
    parameter int ROM_LAT      = 1,
    parameter int SCREEN_W     = SCREEN_W_DEFAULT,
    parameter int SCREEN_H     = SCREEN_H_DEFAULT,
    parameter int FLASH_FRAMES = 64,
    parameter int BLINK_HALF   = 4,
    localparam int LOG_N       = $clog2(SPRITE_N),
`ifdef TANK_ANIM_EN
    localparam int ADDR_W      = 2*LOG_N + 1
`else
    localparam int ADDR_W      = 2*LOG_N
`endif
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic [1:0]        dir,
    input  logic              pos_valid,
    input  logic              flash_start,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_hit,
    output logic              flashing
);

    localparam int TA_W = 2*LOG_N;
    localparam int SIZE = SPRITE_N << SCALE_SHIFT;
    localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [TEX_W-1:0] M = TEX_W'(SPRITE_N - 1);

    logic [9:0] pend_x, pend_y, shad_x, shad_y;
    logic [9:0] nxt_x, nxt_y;
    dir_t       pend_dir, shad_dir, nxt_dir;
    logic       frame_tick;

    // A pos_valid landing on the tick cycle bypasses the pending stage.
    assign nxt_x   = pos_valid ? pos_x : pend_x;
    assign nxt_y   = pos_valid ? pos_y : pend_y;
    assign nxt_dir = pos_valid ? dir_t'(dir) : pend_dir;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            frame_tick <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_dir   <= DIR_UP;
            shad_x     <= '0;
            shad_y     <= '0;
            shad_dir   <= DIR_UP;
        end else begin
            frame_tick <= (DrawX == 10'd0) && (DrawY == 10'(SCREEN_H));
            if (pos_valid) begin
                pend_x   <= pos_x;
                pend_y   <= pos_y;
                pend_dir <= dir_t'(dir);
            end
            if (frame_tick) begin
                shad_x   <= nxt_x;
                shad_y   <= nxt_y;
                shad_dir <= nxt_dir;
            end
        end
    end

    // Stage 0: box test and texel coordinates straight off the beam position.
    logic [9:0]        dx, dy;
    logic              in_x, in_y, in_box;
    texel_t            texel;
    logic [TA_W-1:0]   tex_addr;
    logic [ADDR_W-1:0] addr_next;

    assign dx     = DrawX - shad_x;
    assign dy     = DrawY - shad_y;
    assign in_x   = (DrawX >= shad_x) && ({22'd0, dx} < 32'(SIZE)) && ({22'd0, DrawX} < 32'(SCREEN_W));
    assign in_y   = (DrawY >= shad_y) && ({22'd0, dy} < 32'(SIZE)) && ({22'd0, DrawY} < 32'(SCREEN_H));
    assign in_box = in_x && in_y;

    assign texel    = rotate_texel(TEX_W'(dx >> SCALE_SHIFT), TEX_W'(dy >> SCALE_SHIFT), shad_dir, M);
    assign tex_addr = TA_W'({24'd0, texel.sv} * 32'(SPRITE_N) + {24'd0, texel.su});

`ifdef TANK_ANIM_EN
    logic       anim_sel;
    logic [2:0] anim_cnt;

    // Treads only advance on frames where the tank actually moved.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            anim_sel <= 1'b0;
            anim_cnt <= '0;
        end else if (frame_tick && ((nxt_x != shad_x) || (nxt_y != shad_y))) begin
            anim_cnt <= anim_cnt + 3'd1;
            if (anim_cnt == 3'd7) begin
                anim_sel <= ~anim_sel;
            end
        end
    end

    assign addr_next = {anim_sel, tex_addr};
`else
    assign addr_next = tex_addr;
`endif

    // Blink state machine; visibility only ever moves on a frame tick.
    blink_state_t    state;
    logic [FC_W-1:0] fcnt, fcnt_inc;
    logic            visible, vis_inc;

    assign fcnt_inc = fcnt + FC_W'(1);
    assign vis_inc  = ((32'(fcnt_inc) / 32'(BLINK_HALF)) & 32'd1) == 32'd0;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            fcnt     <= '0;
            visible  <= 1'b1;
            flashing <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    visible  <= 1'b1;
                    flashing <= 1'b0;
                    if (flash_start) begin
                        state    <= BLINK;
                        fcnt     <= '0;
                        flashing <= 1'b1;
                    end
                end
                BLINK: begin
                    flashing <= 1'b1;
                    if (flash_start) begin
                        fcnt <= '0;
                        if (frame_tick) begin
                            visible <= 1'b1;
                        end
                    end else if (frame_tick) begin
                        if (fcnt == FC_W'(FLASH_FRAMES - 1)) begin
                            state    <= IDLE;
                            fcnt     <= '0;
                            visible  <= 1'b1;
                            flashing <= 1'b0;
                        end else begin
                            fcnt    <= fcnt_inc;
                            visible <= vis_inc;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: ROM address plus side-band bits, then delayed to meet rom_q.
    logic [1:0] side_s1, side_d;

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address <= '0;
            side_s1     <= '0;
        end else begin
            rom_address <= in_box ? addr_next : '0;
            side_s1     <= {in_box & blank, visible};
        end
    end

    sprite_delay_line #(
        .DEPTH (ROM_LAT),
        .WIDTH (2)
    ) u_side_delay (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .din     (side_s1),
        .dout    (side_d)
    );

    logic hit_next;
    assign hit_next = side_d[1] & side_d[0] & (rom_q != '0);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            pix_hit <= 1'b0;
            pix_idx <= '0;
        end else begin
            pix_hit <= hit_next;
            pix_idx <= hit_next ? rom_q : '0;
        end
    end

endmodule

// File: tb/tb_tank_sprite_renderer.sv
// tb/tb_tank_sprite_renderer.sv - scoreboard bench for tank_sprite_renderer with a 1-cycle ROM stub
module tb_tank_sprite_renderer;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY, pos_x, pos_y;
    logic       blank, pos_valid, flash_start;
    logic [1:0] dir;
    logic [9:0] rom_address;
    logic [3:0] rom_q = 4'd0;
    logic [3:0] pix_idx;
    logic       pix_hit, flashing;

    always #5 vga_clk = ~vga_clk;

    tank_sprite_renderer dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .dir         (dir),
        .pos_valid   (pos_valid),
        .flash_start (flash_start),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .pix_idx     (pix_idx),
        .pix_hit     (pix_hit),
        .flashing    (flashing)
    );

    always @(posedge vga_clk) rom_q <= rom_address[3:0];

    typedef struct {
        string nm;
        int    v0;
        int    v1;
    } exp_t;

    exp_t aq[$];
    exp_t pq[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    logic chk_a = 1'b0, chk_p = 1'b0;
    logic a1 = 1'b0, p1 = 1'b0, p2 = 1'b0, p3 = 1'b0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Output-present markers: address one cycle after drive, pixel three cycles after.
    always @(posedge vga_clk) begin
        a1 <= chk_a;
        p1 <= chk_p;
        p2 <= p1;
        p3 <= p2;
    end

    always @(negedge vga_clk) begin
        if (a1) begin
            if (aq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL addr_queue_empty actual=0 required=1");
            end else begin
                mon_e = aq.pop_front();
                check({mon_e.nm, "_addr"}, int'(rom_address), mon_e.v0);
            end
        end
        if (p3) begin
            if (pq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pix_queue_empty actual=0 required=1");
            end else begin
                mon_e = pq.pop_front();
                check({mon_e.nm, "_hit"}, int'(pix_hit), mon_e.v0);
                check({mon_e.nm, "_idx"}, int'(pix_idx), mon_e.v1);
            end
        end
    end

    task automatic drive(input int x, input int y, input bit b);
        @(posedge vga_clk);
        #1;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        blank       = b;
        pos_valid   = 1'b0;
        flash_start = 1'b0;
        reset_n     = 1'b1;
        chk_a       = 1'b0;
        chk_p       = 1'b0;
    endtask

    // ea < 0 skips the address comparison for that pixel.
    task automatic px(input string nm, input int x, input int y, input bit b,
                      input int ea, input int eh, input int ei);
        drive(x, y, b);
        if (ea >= 0) begin
            chk_a = 1'b1;
            aq.push_back('{nm, ea, 0});
        end
        chk_p = 1'b1;
        pq.push_back('{nm, eh, ei});
    endtask

    task automatic set_pos(input int x, input int y, input int d);
        drive(700, 500, 1'b0);
        pos_x     = 10'(x);
        pos_y     = 10'(y);
        dir       = 2'(d);
        pos_valid = 1'b1;
    endtask

    task automatic tick(input bit pv, input int x, input int y, input int d);
        drive(0, 480, 1'b0);
        drive(700, 500, 1'b0);
        if (pv) begin
            pos_x     = 10'(x);
            pos_y     = 10'(y);
            dir       = 2'(d);
            pos_valid = 1'b1;
        end
    endtask

    int  ea, idx, fc;
    bit  inb, vis, in_b;

    initial begin
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b0;
        pos_x = '0; pos_y = '0; dir = '0; pos_valid = 1'b0; flash_start = 1'b0;
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        check("reset_pix_hit", int'(pix_hit), 0);
        check("reset_pix_idx", int'(pix_idx), 0);
        check("reset_flashing", int'(flashing), 0);
        check("reset_rom_address", int'(rom_address), 0);

        // Upright sweep across the full sprite width plus one pixel each side
        set_pos(100, 50, 0);
        tick(0, 0, 0, 0);
        for (int x = 99; x <= 132; x++) begin
            in_b = (x >= 100) && (x <= 131);
            ea   = in_b ? x - 100 : 0;
            idx  = ea & 15;
            px("t1_sweep", x, 50, 1'b1, ea, int'(in_b && idx != 0), in_b ? idx : 0);
        end

        // Rotations: right, down, left
        set_pos(100, 50, 1); tick(0, 0, 0, 0);
        px("t2_right_00", 100, 50, 1'b1, 992, 0, 0);
        px("t2_right_01", 100, 51, 1'b1, 993, 1, 1);
        set_pos(100, 50, 2); tick(0, 0, 0, 0);
        px("t2_down_00", 100, 50, 1'b1, 1023, 1, 15);
        set_pos(100, 50, 3); tick(0, 0, 0, 0);
        px("t2_left_00", 100, 50, 1'b1, 31, 1, 15);
        px("t2_left_10", 101, 50, 1'b1, 63, 1, 15);
        px("t2_left_01", 100, 51, 1'b1, 30, 1, 14);

        // Double buffering: mid-frame update waits for the tick
        set_pos(100, 50, 0); tick(0, 0, 0, 0);
        drive(0, 100, 1'b1);
        pos_x = 10'd200; pos_y = 10'd200; dir = 2'd0; pos_valid = 1'b1;
        px("t3_old_still", 105, 60, 1'b1, 325, 1, 5);
        px("t3_new_early", 205, 205, 1'b1, 0, 0, 0);
        tick(0, 0, 0, 0);
        px("t3_new", 205, 205, 1'b1, 165, 1, 5);
        px("t3_old_gone", 105, 60, 1'b1, 0, 0, 0);
        tick(1, 300, 100, 0);
        px("t3_on_tick", 301, 101, 1'b1, 33, 1, 1);
        tick(0, 0, 0, 0);
        px("t3_on_tick_kept", 301, 101, 1'b1, 33, 1, 1);

        // Clipping at the right/bottom screen edges and blanking
        set_pos(620, 470, 0); tick(0, 0, 0, 0);
        for (int x = 618; x <= 645; x++) begin
            in_b = (x >= 620) && (x <= 639);
            ea   = in_b ? x - 620 : ((x >= 640) ? -1 : 0);
            idx  = in_b ? ((x - 620) & 15) : 0;
            px("t4_edge", x, 470, 1'b1, ea, int'(in_b && idx != 0), idx);
        end
        px("t4_below", 625, 485, 1'b1, -1, 0, 0);
        px("t4_blank", 625, 470, 1'b0, 5, 0, 0);

        // Blink: 4 visible / 4 hidden frames, restart after tick 30
        set_pos(100, 50, 0); tick(0, 0, 0, 0);
        drive(700, 500, 1'b0);
        flash_start = 1'b1;
        drive(700, 500, 1'b0);
        @(negedge vga_clk);
        check("t5_flashing_start", int'(flashing), 1);
        fc = 0; inb = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick(0, 0, 0, 0);
            if (inb) begin
                if (fc == 63) inb = 1'b0;
                else fc++;
            end
            vis = !inb || (((fc / 4) % 2) == 0);
            px($sformatf("t5_vis_k%0d", k), 101, 50, 1'b1, 1, int'(vis), vis ? 1 : 0);
            @(negedge vga_clk);
            check($sformatf("t5_flashing_k%0d", k), int'(flashing), int'(inb));
            if (k == 30) begin
                drive(700, 500, 1'b0);
                flash_start = 1'b1;
                fc = 0;
            end
        end

        // Mid-line reset flushes the pipeline and returns the sprite to the origin
        drive(700, 500, 1'b0);
        flash_start = 1'b1;
        drive(700, 500, 1'b0);
        @(negedge vga_clk);
        check("t6_flashing_before", int'(flashing), 1);
        px("t6_p101", 101, 50, 1'b1, 1, 0, 0);
        px("t6_p102", 102, 50, 1'b1, 2, 0, 0);
        px("t6_p103", 103, 50, 1'b1, 0, 0, 0);
        reset_n = 1'b0;
        px("t6_p104", 104, 50, 1'b1, 0, 0, 0);
        @(negedge vga_clk);
        check("t6_flashing_after", int'(flashing), 0);
        check("t6_pix_hit_after", int'(pix_hit), 0);
        check("t6_pix_idx_after", int'(pix_idx), 0);
        check("t6_rom_address_after", int'(rom_address), 0);
        px("t6_origin", 5, 3, 1'b1, 101, 1, 5);

        repeat (6) drive(700, 500, 1'b0);
        check("drain_addr_queue", aq.size(), 0);
        check("drain_pix_queue", pq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
